// File: rtl/seq_multiplier.sv
// Iterative radix-2 shift-add multiplier for RV32M MUL/MULH/MULHSU/MULHU (one add per cycle).
// Optional MUL_ZERO_BYPASS_EN: a zero operand skips the shift-add loop. WIDTH must be a multiple of 4.
module seq_multiplier #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       OP,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             valid,
    output logic [WIDTH-1:0] RESULT
);

    localparam int unsigned PW    = 2 * WIDTH;
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam int unsigned NGRP  = WIDTH / 4;

    localparam logic [1:0] OP_MUL   = 2'b00;
    localparam logic [1:0] OP_MULHU = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        SIGN = 2'b10,
        DONE = 2'b11
    } state_t;

    state_t            state_q, state_nx;
    logic [1:0]        op_q, op_nx;
    logic [WIDTH-1:0]  a_q, a_nx;
    logic [PW-1:0]     acc_q, acc_nx;
    logic [CNT_W-1:0]  cnt_q, cnt_nx;
    logic              neg_q, neg_nx;
    logic              busy_q, busy_nx;
    logic              valid_q, valid_nx;
    logic [WIDTH-1:0]  result_q, result_nx;

    logic              a_neg, b_neg;
    logic [WIDTH-1:0]  a_abs, b_abs;
    logic [WIDTH-1:0]  add_sum;
    logic              add_cout;
    logic [PW-1:0]     product;

    // Operand sign handling: A is signed unless MULHU, B is signed only for MUL/MULH.
    assign a_neg = (OP != OP_MULHU) && A[WIDTH-1];
    assign b_neg = (OP[1] == 1'b0) && B[WIDTH-1];
    assign a_abs = a_neg ? (~A + WIDTH'(1)) : A;
    assign b_abs = b_neg ? (~B + WIDTH'(1)) : B;

    assign product = neg_q ? (~acc_q + PW'(1)) : acc_q;

    // Partial-product adder: 4-bit carry-lookahead groups, group carries chained.
    always_comb begin : cla_add
        logic       c;
        logic [3:0] g;
        logic [3:0] p;
        c       = 1'b0;
        g       = '0;
        p       = '0;
        add_sum = '0;
        for (int i = 0; i < int'(NGRP); i++) begin
            g = acc_q[WIDTH + i*4 +: 4] & a_q[i*4 +: 4];
            p = acc_q[WIDTH + i*4 +: 4] ^ a_q[i*4 +: 4];
            add_sum[i*4]   = p[0] ^ c;
            add_sum[i*4+1] = p[1] ^ (g[0] | (p[0] & c));
            add_sum[i*4+2] = p[2] ^ (g[1] | (p[1] & g[0]) | (p[1] & p[0] & c));
            add_sum[i*4+3] = p[3] ^ (g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                                     | (p[2] & p[1] & p[0] & c));
            c = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                | (&p & c);
        end
        add_cout = c;
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            op_q     <= '0;
            a_q      <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_nx;
            op_q     <= op_nx;
            a_q      <= a_nx;
            acc_q    <= acc_nx;
            cnt_q    <= cnt_nx;
            neg_q    <= neg_nx;
            busy_q   <= busy_nx;
            valid_q  <= valid_nx;
            result_q <= result_nx;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nx  = state_q;
        op_nx     = op_q;
        a_nx      = a_q;
        acc_nx    = acc_q;
        cnt_nx    = cnt_q;
        neg_nx    = neg_q;
        busy_nx   = busy_q;
        valid_nx  = 1'b0;
        result_nx = result_q;

        case (state_q)
            IDLE, DONE: begin
                if (state_q == DONE) begin
                    state_nx = IDLE;
                end
                if (start) begin
                    op_nx    = OP;
                    a_nx     = a_abs;
                    acc_nx   = {{WIDTH{1'b0}}, b_abs};
                    cnt_nx   = '0;
                    neg_nx   = a_neg ^ b_neg;
                    busy_nx  = 1'b1;
                    state_nx = CALC;
`ifdef MUL_ZERO_BYPASS_EN
                    // Zero operand: product is known, only the result-load cycle remains.
                    if ((A == '0) || (B == '0)) begin
                        acc_nx   = '0;
                        neg_nx   = 1'b0;
                        state_nx = SIGN;
                    end
`endif
                end
            end
            CALC: begin
                if (acc_q[0]) begin
                    acc_nx = {add_cout, add_sum, acc_q[WIDTH-1:1]};
                end else begin
                    acc_nx = {1'b0, acc_q[PW-1:1]};
                end
                cnt_nx = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_nx = SIGN;
                end
            end
            SIGN: begin
                result_nx = (op_q == OP_MUL) ? product[WIDTH-1:0] : product[PW-1:WIDTH];
                busy_nx   = 1'b0;
                valid_nx  = 1'b1;
                state_nx  = DONE;
            end
            default: begin
                state_nx = IDLE;
                busy_nx  = 1'b0;
            end
        endcase
    end

    assign busy   = busy_q;
    assign valid  = valid_q;
    assign RESULT = result_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed-vector bench for seq_multiplier (WIDTH=32), immediate-assertion checks.
module tb_seq_multiplier;

    localparam int unsigned WIDTH = 32;
    localparam int LAT = 33;
`ifdef MUL_ZERO_BYPASS_EN
    localparam int ZERO_LAT = 1;
`else
    localparam int ZERO_LAT = 33;
`endif

    logic             clk;
    logic             reset;
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             valid;
    logic [WIDTH-1:0] result;

    int total = 0;
    int bad   = 0;

    seq_multiplier #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .OP     (op),
        .A      (a),
        .B      (b),
        .busy   (busy),
        .valid  (valid),
        .RESULT (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive a request for one edge (edge 0), then scramble operands to prove they were latched.
    task automatic launch(input logic [1:0] o, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(posedge clk);
        #1;
        start = 1'b0;
        op    = 2'b01;
        a     = 32'hDEAD_BEEF;
        b     = 32'h1357_9BDF;
    endtask

    // Count edges after edge 0 until valid is seen; busy must stay high meanwhile.
    task automatic wait_valid(output int n, output logic busy_ok);
        n       = 0;
        busy_ok = 1'b1;
        while (valid !== 1'b1 && n < 100) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic run_op(input string tag, input logic [1:0] o, input logic [WIDTH-1:0] x,
                          input logic [WIDTH-1:0] y, input logic [WIDTH-1:0] exp_res,
                          input int exp_lat);
        int   n;
        logic bok;
        @(negedge clk);
        launch(o, x, y);
        wait_valid(n, bok);
        chk({tag, "_lat"}, 32'(n), 32'(exp_lat));
        chk({tag, "_busy_run"}, {31'd0, bok}, 32'd1);
        chk({tag, "_res"}, result, exp_res);
        chk({tag, "_busy_at_valid"}, {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;
        chk({tag, "_pulse"}, {31'd0, valid}, 32'd0);
        chk({tag, "_hold"}, result, exp_res);
    endtask

    initial begin
        int   n;
        logic bok;
        reset = 1'b1;
        start = 1'b0;
        op    = 2'b00;
        a     = '0;
        b     = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_valid", {31'd0, valid}, 32'd0);
        chk("rst_result", result, 32'd0);
        reset = 1'b0;

        run_op("mul_7x6", 2'b00, 32'd7, 32'd6, 32'h0000_002A, LAT);
        run_op("mulh_min", 2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, LAT);
        run_op("mul_min", 2'b00, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, LAT);
        run_op("mulhsu_m1", 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, LAT);
        run_op("mulhu_max", 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, LAT);
        run_op("mul_m1", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, LAT);

        // MULH -3*5, then MUL -3*5 started in the DONE cycle.
        @(negedge clk);
        launch(2'b01, 32'hFFFF_FFFD, 32'd5);
        wait_valid(n, bok);
        chk("mulh_neg_lat", 32'(n), 32'(LAT));
        chk("mulh_neg_res", result, 32'hFFFF_FFFF);
        launch(2'b00, 32'hFFFF_FFFD, 32'd5);
        chk("b2b_pulse", {31'd0, valid}, 32'd0);
        chk("b2b_busy", {31'd0, busy}, 32'd1);
        wait_valid(n, bok);
        chk("b2b_lat", 32'(n), 32'(LAT));
        chk("b2b_busy_run", {31'd0, bok}, 32'd1);
        chk("b2b_res", result, 32'hFFFF_FFF1);

        // Start while busy is ignored: 3*4 completes untouched.
        @(negedge clk);
        launch(2'b00, 32'd3, 32'd4);
        repeat (4) @(posedge clk);
        #1;
        start = 1'b1;
        op    = 2'b11;
        a     = 32'd9;
        b     = 32'd9;
        @(posedge clk);
        #1;
        start = 1'b0;
        n = 5;
        bok = 1'b1;
        while (valid !== 1'b1 && n < 100) begin
            if (busy !== 1'b1) bok = 1'b0;
            @(posedge clk);
            #1;
            n++;
        end
        chk("ign_lat", 32'(n), 32'(LAT));
        chk("ign_busy_run", {31'd0, bok}, 32'd1);
        chk("ign_res", result, 32'h0000_000C);

        // Abort mid-CALC with reset; outputs clear immediately.
        @(negedge clk);
        launch(2'b00, 32'd3, 32'd4);
        repeat (4) @(posedge clk);
        #1;
        start = 1'b1;
        a     = 32'd9;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("abort_busy_pre", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_valid", {31'd0, valid}, 32'd0);
        chk("abort_result", result, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("abort_no_valid", {31'd0, valid}, 32'd0);
        run_op("mul_9x9", 2'b00, 32'd9, 32'd9, 32'h0000_0051, LAT);

        // Zero operand.
        run_op("mul_zero", 2'b00, 32'd0, 32'h0000_1234, 32'h0000_0000, ZERO_LAT);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
